any1_fetch_aligner: RTL

- Sits between the instruction fetch port and decode.
- Accepts naturally aligned 8-byte fetch words and buffers them in a byte queue.
- Extracts one variable-length ANY-1 instruction per cycle: 2, 4 or 6 bytes, sized from its opcode byte. Each instruction is presented left-justified with its PC and length.
- Handles redirects, including a non-aligned target PC inside the first fetched word.

---
 rtl/any1_pkg.sv | 14 +
 rtl/any1_align_queue.sv | 35 +++
 rtl/any1_fetch_aligner.sv | 64 ++++++
 3 files changed

// File: rtl/any1_pkg.sv
// any1_pkg: opcode constants, aligned-instruction bundle and length decode for the fetch aligner
package any1_pkg;
  localparam logic [7:0] LDXL = 8'h8A;
  localparam logic [7:0] STXL = 8'h9A;
  localparam int PC_W = 32;
  typedef struct packed {
    logic [47:0]     ins;
    logic [2:0]      len;
    logic [PC_W-1:0] pc;
  } any1_ins_t;
  function automatic logic [2:0] ins_len(input logic [7:0] op);
    return (op == LDXL || op == STXL) ? 3'd6 : (op[7:4] == 4'h5) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/any1_align_queue.sv
// any1_align_queue: 16-byte head-first byte queue with a merged shift-by-len and append-at-offset
module any1_align_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [2:0]  len,
  input  logic [2:0]  skip,
  input  logic [63:0] dat,
  output logic [47:0] head,
  output logic [4:0]  cnt
);
  logic [127:0] q_buf, buf_d, sh, wd;
  logic [4:0]   cnt_q, cnt_d, base;
  always_comb begin
    sh = pop ? q_buf >> {len, 3'b000} : q_buf;
    base = pop ? cnt_q - {2'b00, len} : cnt_q;
    cnt_d = push ? base + 5'd8 - {2'b00, skip} : base;
    wd = {64'b0, dat >> {skip, 3'b000}} << {base, 3'b000};
    // bytes below base survive the shift, the new word lands from base up to cnt_d
    for (int i = 0; i < 16; i++)
      buf_d[i*8 +: 8] = 5'(i) < base ? sh[i*8 +: 8] : 5'(i) < cnt_d ? wd[i*8 +: 8] : 8'h00;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_buf <= '0;
      cnt_q <= '0;
    end else begin
      q_buf <= buf_d;
      cnt_q <= flush ? 5'd0 : cnt_d;
    end
  assign head = q_buf[47:0];
  assign cnt = cnt_q;
endmodule

// File: rtl/any1_fetch_aligner.sv
// any1_fetch_aligner: turns aligned 8-byte fetch words into one left-justified 2/4/6-byte instruction per cycle
module any1_fetch_aligner
  import any1_pkg::*;
#(
  parameter int             AWID  = 32,
  parameter logic [AWID-1:0] RSTPC = 32'hFFFC0100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fw_valid_i,
  output logic            fw_ready_o,
  input  logic [63:0]     fw_dat_i,
  input  logic            redir_i,
  input  logic [AWID-1:0] redir_pc_i,
  output logic            ins_valid_o,
  input  logic            ins_ready_i,
  output logic [47:0]     ins_o,
  output logic [2:0]      ins_len_o,
  output logic [AWID-1:0] ins_pc_o
);
  logic [AWID-1:0] pc;
  logic [2:0]      skip, len;
  logic [47:0]     head;
  logic [4:0]      cnt;
  logic            accept, consume;
  any1_ins_t       ob;
  assign len = ins_len(head[7:0]);
  assign ins_valid_o = cnt >= 5'd2 && cnt >= {2'b00, len};
  assign fw_ready_o = cnt <= 5'd8;
  assign accept = fw_valid_i && fw_ready_o && !redir_i;
  assign consume = ins_valid_o && ins_ready_i && !redir_i;
  always_comb begin
    ob.len = len;
    ob.pc = PC_W'(pc);
    ob.ins = head & (len == 3'd2 ? 48'h0000_0000_FFFF : len == 3'd4 ? 48'h0000_FFFF_FFFF : {48{1'b1}});
  end
  assign ins_o = ob.ins;
  assign ins_len_o = ob.len;
  assign ins_pc_o = AWID'(ob.pc);
  // redirect wins over both handshakes; the low pc bits say how much of the first word to drop
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc <= RSTPC;
      skip <= RSTPC[2:0];
    end else if (redir_i) begin
      pc <= redir_pc_i;
      skip <= redir_pc_i[2:0];
    end else begin
      if (consume) pc <= pc + AWID'(len);
      if (accept) skip <= 3'd0;
    end
  any1_align_queue u_queue (
    .clk  (clk_i),
    .rst  (rst_i),
    .flush(redir_i),
    .push (accept),
    .pop  (consume),
    .len  (len),
    .skip (skip),
    .dat  (fw_dat_i),
    .head (head),
    .cnt  (cnt)
  );
endmodule
